spi_sram_bridge: RTL and testbench
==================================

Name: spi_sram_bridge

Overview:
- Responder side of the memory request interface driven by the memory controller.
- Accepts word read/write requests and performs them on an external serial SRAM (23LC1024-class, SPI mode 0, byte addressed, sequential mode) over SPI.
- Signals request acceptance with `ready`, and read completion with `rdata_valid`.
- Sits between the memory controller and the off-chip SRAM pads; its `ready` is the controller's `off_chip_mem_ready`.

Parameters:
- CLK_DIV, 2, SCK half-period in clk cycles (>=1).
- CS_IDLE, 2, minimum clk cycles `cs_n` stays high between transactions (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req  input  1  request valid from controller.
- we  input  1  1 = write, 0 = read; sampled at accept.
- address  input  16  word address; sampled at accept.
- wdata  input  16  write data; sampled at accept.
- ready  output  1  bridge idle; a request is accepted on a clk edge where req && ready.
- rdata  output  16  read data; holds its value until the next read completes.
- rdata_valid  output  1  one-cycle pulse when rdata updates.
- spi_sck  output  1  SPI clock, idle low.
- spi_cs_n  output  1  SPI chip select, active low.
- spi_mosi  output  1  SPI data out.
- spi_miso  input  1  SPI data in.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high; it dominates all other inputs and aborts any transaction immediately.
- Reset values:
  - ready=1, spi_cs_n=1, spi_sck=0, spi_mosi=0.
  - rdata=0x0000, rdata_valid=0.
  - FSM=IDLE, all counters 0.
- Frame: 48 bits, MSB first.
  - Command byte: 0x02 for a write, 0x03 for a read.
  - Byte address, 24 bits: {7'b0, address, 1'b0}.
  - 16 data bits: wdata for a write; don't-care (0) on mosi for a read.
- FSM:
  - IDLE: ready=1. On req && ready, latch we/address/wdata, go to SETUP, ready=0 on the next cycle. A req while ready=0 is ignored; no queueing.
  - SETUP: spi_cs_n=0, spi_mosi=frame bit 47, spi_sck=0. Lasts CLK_DIV cycles, then SHIFT.
  - SHIFT: spi_sck toggles every CLK_DIV cycles, for 48 rising and 48 falling edges.
    - Rising edge: shift spi_miso into the 16-bit rx register (only the last 16 samples matter).
    - Falling edge: advance spi_mosi to the next frame bit.
    - After the 48th falling edge, go to HOLD.
  - HOLD: spi_sck=0, spi_cs_n=0 for CLK_DIV cycles. Then spi_cs_n=1 and go to GAP.
  - GAP: spi_cs_n=1 for CS_IDLE cycles.
    - On the first GAP cycle, a read sets rdata=rx and pulses rdata_valid for exactly one cycle. A write pulses nothing.
    - After CS_IDLE cycles, go to IDLE with ready=1.
- Latency:
  - Accept edge to ready re-high: 98*CLK_DIV + CS_IDLE cycles (198 at defaults).
  - Accept edge to spi_cs_n rising: 98*CLK_DIV (196 at defaults).
  - rdata_valid coincides with the first spi_cs_n=1 cycle.
- Back-to-back: if req is held high, the next accept occurs on the first cycle ready=1. spi_cs_n high time is therefore CS_IDLE+1 cycles minimum.
- Bit counter: 6 bits, range 0..47. No wrap inside a frame.
- Address: no address wrap logic; the full 16-bit word space maps to 128 KiB.
- Stability: spi_mosi changes only on spi_sck falling or in SETUP. spi_sck is never high while spi_cs_n=1.
- Reset mid-transaction: the next cycle shows IDLE values.
  - spi_cs_n goes to 1 and spi_sck to 0 with no further edges.
  - No rdata_valid pulse. rdata returns to 0 per reset.
- Inputs changing after accept have no effect on the current frame.

Test Plan:
- Write: reset, then req=1, we=1, address=0x1234, wdata=0xBEEF for one cycle. Required: ready=0 next cycle; MOSI sampled on SCK rising edges = 0x02,0x00,0x24,0x68,0xBE,0xEF; exactly 48 SCK rising edges; spi_cs_n rises 196 cycles after accept; ready=1 at 198; rdata_valid never asserts.
- Read: req with we=0, address=0x0001, and an SRAM model driving 0xA55A on the data phase. Required: MOSI = 0x03,0x00,0x00,0x02; rdata=0xA55A with rdata_valid high for exactly one cycle, on the first spi_cs_n=1 cycle.
- Back-to-back: req held high for two requests (write then read). Required: second accept on the first ready=1 cycle; spi_cs_n high >= 3 cycles between frames; second frame correct.
- Ignored request: pulse req mid-frame. Required: no effect on the current frame and no extra frame afterwards.
- Reset mid-SHIFT: assert reset after the 20th SCK rising edge. Required: the next cycle shows spi_cs_n=1, spi_sck=0, ready=1, rdata=0, and no rdata_valid. A following read completes normally.
- CLK_DIV=1, CS_IDLE=1: read at 0xFFFF with model data 0x0F0F. Required: byte address 0x01FFFE on MOSI; ready re-high 99 cycles after accept; rdata=0x0F0F.

Source files
------------

// File: rtl/spi_sram_bridge.sv
// spi_sram_bridge: memory-request responder driving a 23LC1024-class serial
// SRAM over SPI mode 0 (48-bit frame: cmd, 24-bit byte address, 16 data bits).
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   req, we, address,      - request from the memory controller,
//   wdata                  -   accepted when req && ready
//   ready                  - bridge idle
//   rdata, rdata_valid     - read result and its one-cycle update strobe
//   spi_sck, spi_cs_n,     - SPI pins to the SRAM
//   spi_mosi, spi_miso
module spi_sram_bridge #(
   parameter int CLK_DIV = 2,
   parameter int CS_IDLE = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] address,
   input  logic [15:0] wdata,
   output logic        ready,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   output logic        spi_sck,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(CS_IDLE - 1);

   logic [2:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [5:0]  bit_q, bit_d;
   logic        sck_q, sck_d;
   logic [47:0] frame_q, frame_d;
   logic [15:0] rx_q, rx_d;
   logic        we_q, we_d;
   logic [15:0] rdata_q, rdata_d;
   logic        valid_q, valid_d;
   logic        tick;

   // cnt_q is a per-phase cycle counter; tick marks the last cycle of
   // an SCK half-period (also used to time SETUP and HOLD).
   assign tick = (cnt_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      sck_d   = sck_q;
      frame_d = frame_q;
      rx_d    = rx_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      valid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = 16'd0;
            if (req) begin
               state_d = S_SETUP;
               we_d    = we;
               bit_d   = 6'd0;
               frame_d = {(we ? 8'h02 : 8'h03), 7'b0, address, 1'b0,
                          (we ? wdata : 16'h0000)};
            end
         end
         S_SETUP: begin
            if (tick) begin
               cnt_d   = 16'd0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (tick) begin
               cnt_d = 16'd0;
               sck_d = ~sck_q;
               if (!sck_q) begin
                  rx_d = {rx_q[14:0], spi_miso};
               end else if (bit_q == 6'd47) begin
                  // frame cleared so mosi idles low once the last bit is out
                  state_d = S_HOLD;
                  bit_d   = 6'd0;
                  frame_d = '0;
               end else begin
                  bit_d   = bit_q + 6'd1;
                  frame_d = {frame_q[46:0], 1'b0};
               end
            end
         end
         S_HOLD: begin
            if (tick) begin
               cnt_d   = 16'd0;
               state_d = S_GAP;
               if (!we_q) begin
                  rdata_d = rx_q;
                  valid_d = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = 16'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         bit_q   <= 6'd0;
         sck_q   <= 1'b0;
         frame_q <= '0;
         rx_q    <= 16'h0000;
         we_q    <= 1'b0;
         rdata_q <= 16'h0000;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sck_q   <= sck_d;
         frame_q <= frame_d;
         rx_q    <= rx_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
      end
   end

   assign ready       = (state_q == S_IDLE);
   assign spi_cs_n    = (state_q == S_IDLE) || (state_q == S_GAP);
   assign spi_sck     = sck_q;
   assign spi_mosi    = frame_q[47];
   assign rdata       = rdata_q;
   assign rdata_valid = valid_q;

endmodule

// File: tb/tb_spi_sram_bridge.sv
// tb_spi_sram_bridge: timeline model of the SPI SRAM bridge plus serial SRAM,
// checked every cycle against two DUTs (default and CLK_DIV=1/CS_IDLE=1).
module tb_spi_sram_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0 = 1'b1, req0 = 1'b0, we0 = 1'b0, miso0 = 1'b0;
   logic [15:0] addr0 = '0, wd0 = '0;
   logic        rdy0, csn0, sck0, mosi0, vld0;
   logic [15:0] rd0;
   logic        rst1 = 1'b1, req1 = 1'b0, we1 = 1'b0, miso1 = 1'b0;
   logic [15:0] addr1 = '0, wd1 = '0;
   logic        rdy1, csn1, sck1, mosi1, vld1;
   logic [15:0] rd1;

   spi_sram_bridge u0 (
      .clk(clk), .reset(rst0), .req(req0), .we(we0), .address(addr0),
      .wdata(wd0), .ready(rdy0), .rdata(rd0), .rdata_valid(vld0),
      .spi_sck(sck0), .spi_cs_n(csn0), .spi_mosi(mosi0), .spi_miso(miso0)
   );

   spi_sram_bridge #(.CLK_DIV(1), .CS_IDLE(1)) u1 (
      .clk(clk), .reset(rst1), .req(req1), .we(we1), .address(addr1),
      .wdata(wd1), .ready(rdy1), .rdata(rd1), .rdata_valid(vld1),
      .spi_sck(sck1), .spi_cs_n(csn1), .spi_mosi(mosi1), .spi_miso(miso1)
   );

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [47:0] act,
                      input logic [47:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: m counts clk edges since the accept edge (0 = accept edge).
   int          kd [2] = '{2, 1};
   int          kc [2] = '{2, 1};
   logic        act [2] = '{1'b0, 1'b0};
   int          m [2] = '{0, 0};
   logic        mwe [2];
   logic [15:0] maddr [2];
   logic [15:0] mdat [2];
   logic [47:0] mfr [2];
   logic [15:0] mrd [2] = '{16'h0, 16'h0};
   logic [15:0] mem [int];
   bit          en = 0;

   task automatic adv(input int i, input logic rs, input logic rq,
                      input logic w, input logic [15:0] a,
                      input logic [15:0] wd);
      int d;
      int key;
      d = kd[i];
      key = i * 65536 + int'(a);
      if (rs) begin
         act[i] = 1'b0;
         mrd[i] = 16'h0;
      end else if (act[i]) begin
         m[i]++;
         if (m[i] == 98 * d) begin
            if (mwe[i]) mem[i * 65536 + int'(maddr[i])] = mdat[i];
            else mrd[i] = mdat[i];
         end
         if (m[i] == 98 * d + kc[i]) act[i] = 1'b0;
      end else if (rq) begin
         act[i] = 1'b1;
         m[i] = 0;
         mwe[i] = w;
         maddr[i] = a;
         if (w) mdat[i] = wd;
         else if (mem.exists(key)) mdat[i] = mem[key];
         else mdat[i] = 16'h0;
         mfr[i] = {(w ? 8'h02 : 8'h03), 7'b0, a, 1'b0, (w ? wd : 16'h0)};
      end
   endtask

   always @(posedge clk) begin
      adv(0, rst0, req0, we0, addr0, wd0);
      adv(1, rst1, req1, we1, addr1, wd1);
   end

   task automatic cmp(input int i, input logic r, input logic c,
                      input logic s, input logic mo, input logic v,
                      input logic [15:0] rd);
      int d;
      int j;
      logic es;
      d = kd[i];
      es = act[i] && m[i] >= d && m[i] < 97 * d && ((m[i] - d) / d) % 2 == 1;
      chk($sformatf("ready%0d", i), r, !act[i]);
      chk($sformatf("cs_n%0d", i), c, !act[i] || m[i] >= 98 * d);
      chk($sformatf("sck%0d", i), s, es);
      chk($sformatf("rvalid%0d", i), v, act[i] && !mwe[i] && m[i] == 98 * d);
      chk($sformatf("rdata%0d", i), rd, mrd[i]);
      if (act[i] && m[i] < 97 * d) begin
         j = (m[i] < d) ? 0 : (m[i] - d) / (2 * d);
         chk($sformatf("mosi%0d", i), mo, mfr[i][47 - j]);
      end
   endtask

   always @(negedge clk) begin
      if (en) begin
         cmp(0, rdy0, csn0, sck0, mosi0, vld0, rd0);
         cmp(1, rdy1, csn1, sck1, mosi1, vld1, rd1);
      end
   end

   // SRAM data phase: present data bit for rising edge k (33..48) ahead of it.
   function automatic logic miso_bit(input int i, input logic cur);
      int d;
      int e;
      int k;
      d = kd[i];
      if (!act[i] || mwe[i]) return 1'b0;
      e = m[i] + 1;
      if (e % (2 * d) != 0) return cur;
      k = e / (2 * d);
      if (k < 33 || k > 48) return cur;
      return mdat[i][48 - k];
   endfunction

   always @(negedge clk) begin
      miso0 = miso_bit(0, miso0);
      miso1 = miso_bit(1, miso1);
   end

   logic [47:0] cap0 = '0, cap1 = '0, lf0 = '0, lf1 = '0;
   int          rc0 = 0, rc1 = 0, lr0 = 0, lr1 = 0;
   int          vc0 = 0, vc1 = 0;

   always @(posedge sck0 or negedge csn0)
      if (sck0) begin cap0 = {cap0[46:0], mosi0}; rc0++; end
      else begin cap0 = '0; rc0 = 0; end
   always @(posedge sck1 or negedge csn1)
      if (sck1) begin cap1 = {cap1[46:0], mosi1}; rc1++; end
      else begin cap1 = '0; rc1 = 0; end
   always @(posedge csn0) begin lf0 = cap0; lr0 = rc0; end
   always @(posedge csn1) begin lf1 = cap1; lr1 = rc1; end
   always @(negedge clk) begin
      if (vld0 === 1'b1) vc0++;
      if (vld1 === 1'b1) vc1++;
   end

   task automatic drive(input int i, input logic rq, input logic w,
                        input logic [15:0] a, input logic [15:0] wd);
      if (i == 0) begin req0 = rq; we0 = w; addr0 = a; wd0 = wd; end
      else begin req1 = rq; we1 = w; addr1 = a; wd1 = wd; end
   endtask

   function automatic logic rdy(input int i);
      return (i == 0) ? rdy0 : rdy1;
   endfunction

   function automatic logic csn(input int i);
      return (i == 0) ? csn0 : csn1;
   endfunction

   task automatic timeout(input string nm);
      nchk++;
      nerr++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   // One request; inputs are scrambled after accept. pulse_at >= 0 raises
   // req for one cycle at that sample while the bridge is busy.
   task automatic txn(input int i, input logic w, input logic [15:0] a,
                      input logic [15:0] wd, input int pulse_at,
                      output int tcs, output int trdy);
      int n;
      n = 0;
      tcs = -1;
      trdy = -1;
      @(negedge clk);
      drive(i, 1'b1, w, a, wd);
      @(negedge clk);
      while (trdy < 0 && n < 500) begin
         drive(i, n == pulse_at, ~w, ~a, ~wd);
         if (tcs < 0 && csn(i)) tcs = n;
         if (rdy(i)) trdy = n;
         else begin @(negedge clk); n++; end
      end
      drive(i, 1'b0, 1'b0, 16'h0, 16'h0);
      if (trdy < 0) timeout("txn");
   endtask

   int tcs, trdy, n, hi, rhi, v;

   initial begin
      mem[1] = 16'hA55A;
      mem[65536 + 65535] = 16'h0F0F;
      repeat (3) @(negedge clk);
      chk("rst_ready", rdy0, 1'b1);
      chk("rst_cs_n", csn0, 1'b1);
      chk("rst_sck", sck0, 1'b0);
      chk("rst_mosi", mosi0, 1'b0);
      chk("rst_rdata", rd0, 16'h0);
      chk("rst_rvalid", vld0, 1'b0);
      rst0 = 1'b0;
      rst1 = 1'b0;
      en = 1;

      v = vc0;
      txn(0, 1'b1, 16'h1234, 16'hBEEF, -1, tcs, trdy);
      chk("wr_cs_rise", 48'(tcs), 48'd196);
      chk("wr_ready", 48'(trdy), 48'd198);
      chk("wr_frame", lf0, 48'h02002468BEEF);
      chk("wr_edges", 48'(lr0), 48'd48);
      chk("wr_no_valid", 48'(vc0 - v), 48'd0);

      v = vc0;
      txn(0, 1'b0, 16'h0001, 16'h0, -1, tcs, trdy);
      chk("rd_cmd_addr", lf0[47:16], 32'h03000002);
      chk("rd_data", rd0, 16'hA55A);
      chk("rd_valid_once", 48'(vc0 - v), 48'd1);

      @(negedge clk);
      drive(0, 1'b1, 1'b1, 16'h0100, 16'h1357);
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
      n = 0;
      hi = 0;
      rhi = 0;
      while (n < 600 && !(hi > 0 && !csn0)) begin
         if (csn0) hi++;
         if (rdy0) rhi++;
         @(negedge clk);
         n++;
      end
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      if (n >= 600) timeout("b2b_gap");
      chk("b2b_cs_high", 48'(hi), 48'd3);
      chk("b2b_ready_cyc", 48'(rhi), 48'd1);
      chk("b2b_frame1", lf0, 48'h020002001357);
      n = 0;
      while (n < 600 && !rdy0) begin @(negedge clk); n++; end
      if (n >= 600) timeout("b2b_second");
      chk("b2b_frame2", lf0[47:16], 32'h03000200);
      chk("b2b_rdata", rd0, 16'h1357);

      v = vc0;
      txn(0, 1'b0, 16'h1234, 16'h0, 100, tcs, trdy);
      chk("ign_cs_rise", 48'(tcs), 48'd196);
      chk("ign_frame", lf0[47:16], 32'h03002468);
      chk("ign_rdata", rd0, 16'hBEEF);
      repeat (20) @(negedge clk);
      chk("ign_no_extra", 48'(vc0 - v), 48'd1);

      v = vc0;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 16'h0001, 16'h0);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
      n = 0;
      while (n < 300 && rc0 < 20) begin @(negedge clk); n++; end
      if (n >= 300) timeout("rst_mid");
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
      chk("mid_cs_n", csn0, 1'b1);
      chk("mid_sck", sck0, 1'b0);
      chk("mid_ready", rdy0, 1'b1);
      chk("mid_rdata", rd0, 16'h0);
      chk("mid_rvalid", vld0, 1'b0);
      repeat (10) @(negedge clk);
      chk("mid_no_edges", 48'(rc0), 48'd20);
      chk("mid_no_valid", 48'(vc0 - v), 48'd0);
      txn(0, 1'b0, 16'h0001, 16'h0, -1, tcs, trdy);
      chk("mid_after_rd", rd0, 16'hA55A);
      chk("mid_after_lat", 48'(trdy), 48'd198);

      v = vc1;
      txn(1, 1'b0, 16'hFFFF, 16'h0, -1, tcs, trdy);
      chk("d1_cs_rise", 48'(tcs), 48'd98);
      chk("d1_ready", 48'(trdy), 48'd99);
      chk("d1_cmd_addr", lf1[47:16], 32'h0301FFFE);
      chk("d1_edges", 48'(lr1), 48'd48);
      chk("d1_rdata", rd1, 16'h0F0F);
      chk("d1_valid_once", 48'(vc1 - v), 48'd1);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
